branch_resolve_ctrl: RTL

- Sequences branch resolution for the control unit.
- Owns the architectural NZCV flag register and tracks in-flight flag-writing instructions.
- Accepts one conditional branch at a time and stalls until flags are current.
- Evaluates the 3-bit branch condition, then issues a PC redirect and a fixed-length pipeline flush when the branch is taken.

---
 rtl/branch_resolve_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: owns NZCV, tracks in-flight flag writers, resolves one branch at a time.
// Optional build macro BRANCH_STATS_EN adds taken/not-taken outcome counters.
module branch_resolve_ctrl #(
   parameter int ADDR_W       = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int MAX_PENDING  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flag_wr_issue,
   input  logic              flag_wr_en,
   input  logic [3:0]        flags_in,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [2:0]        br_cond,
   input  logic [ADDR_W-1:0] br_target,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              flush,
   output logic              stall,
   output logic [3:0]        flags_out,
`ifdef BRANCH_STATS_EN
   output logic [15:0]       taken_cnt,
   output logic [15:0]       not_taken_cnt,
`endif
   output logic [1:0]        pend_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT_FLAGS, RESOLVE, FLUSH} state_t;

   localparam logic [1:0] PEND_MAX   = 2'(MAX_PENDING);
   localparam logic [2:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

   state_t              state;
   logic [2:0]          cond_q;
   logic [ADDR_W-1:0]   tgt_q;
   logic [ADDR_W-1:0]   pc_hold;
   logic [2:0]          fcnt;
   logic [1:0]          pend_nxt;
   logic                cond_true;
   logic                taken_now;
   logic                hs;

   function automatic logic always_taken(input logic [2:0] c);
      return (c == 3'b000) || (c == 3'b001) || (c == 3'b010) || (c == 3'b111);
   endfunction

   // Issue and writeback in the same cycle cancel, even at saturation.
   always_comb begin
      pend_nxt = pend_cnt;
      if (flag_wr_issue && !flag_wr_en && pend_cnt != PEND_MAX)
         pend_nxt = pend_cnt + 2'd1;
      else if (!flag_wr_issue && flag_wr_en && pend_cnt != 2'd0)
         pend_nxt = pend_cnt - 2'd1;
   end

   always_comb begin
      case (cond_q)
         3'b011:  cond_true = flags_out[2];
         3'b100:  cond_true = ~flags_out[2];
         3'b110:  cond_true = flags_out[3] ^ flags_out[0];
         3'b101:  cond_true = ~flags_out[2] & ~(flags_out[3] ^ flags_out[0]);
         default: cond_true = 1'b1;
      endcase
   end

   assign hs             = br_valid & br_ready;
   assign taken_now      = (state == RESOLVE) && cond_true;
   assign br_ready       = (state == IDLE);
   assign redirect_valid = taken_now;
   assign redirect_pc    = taken_now ? tgt_q : pc_hold;
   assign flush          = taken_now || (state == FLUSH);
   assign stall          = (state == WAIT_FLAGS) || (state == RESOLVE) || (pend_cnt == PEND_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         flags_out <= '0;
         pend_cnt  <= '0;
         cond_q    <= '0;
         tgt_q     <= '0;
         pc_hold   <= '0;
         fcnt      <= '0;
      end else begin
         if (flag_wr_en)
            flags_out <= flags_in;
         pend_cnt <= pend_nxt;
         if (taken_now)
            pc_hold <= tgt_q;
         case (state)
            IDLE: begin
               if (hs) begin
                  cond_q <= br_cond;
                  tgt_q  <= br_target;
                  if (always_taken(br_cond) || pend_nxt == 2'd0)
                     state <= RESOLVE;
                  else
                     state <= WAIT_FLAGS;
               end
            end
            WAIT_FLAGS: begin
               if (pend_nxt == 2'd0)
                  state <= RESOLVE;
            end
            RESOLVE: begin
               // The RESOLVE cycle itself counts as the first flush cycle.
               if (cond_true && FLUSH_CYCLES > 1) begin
                  state <= FLUSH;
                  fcnt  <= FLUSH_LOAD;
               end else begin
                  state <= IDLE;
               end
            end
            FLUSH: begin
               if (fcnt == 3'd0)
                  state <= IDLE;
               else
                  fcnt <= fcnt - 3'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         taken_cnt     <= '0;
         not_taken_cnt <= '0;
      end else if (state == RESOLVE) begin
         if (cond_true && taken_cnt != 16'hFFFF)
            taken_cnt <= taken_cnt + 16'd1;
         else if (!cond_true && not_taken_cnt != 16'hFFFF)
            not_taken_cnt <= not_taken_cnt + 16'd1;
      end
   end
`endif

endmodule
